// File: rtl/hazard_pkg.sv
// Shared hazard-tracking types for the register scoreboard.
// Contents:
//   REG_IDX_W      width of an architectural register index
//   NREGS          number of architectural integer registers (x0 is never tracked)
//   decoded_inst_t decode fields the scoreboard consumes from ID
//   sb_cnt_t       default per-register pending counter type
package hazard_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NREGS     = 32;
    localparam int SB_CNT_W  = 2;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [SB_CNT_W-1:0]  sb_cnt_t;

    typedef struct packed {
        reg_idx_t rs1;
        reg_idx_t rs2;
        reg_idx_t rd;
        logic     en_rs1;
        logic     en_rs2;
        logic     en_rd;
        logic     is_mret;
    } decoded_inst_t;

endpackage

// File: rtl/sb_counter.sv
// One clamped up/down counter used by the register scoreboard.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   inc           add one this cycle
//   dec[1:0]      subtract 0..2 this cycle (WB and squash may both hit)
//   cnt           current count
//   underflow     combinational: this cycle's update would go below zero
// A result below zero is held at zero; a result above the top code is
// held at the top code.
module sb_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic [1:0]   dec,
    output logic [W-1:0] cnt,
    output logic         underflow
);

    localparam int NW = W + 2;
    localparam logic signed [NW-1:0] MAXV = NW'((1 << W) - 1);

    // Two extra bits hold both cnt+1 and the -2 corner without wrapping.
    logic signed [NW-1:0] nxt;

    assign nxt       = $signed({2'b00, cnt}) + $signed(NW'(inc)) - $signed(NW'(dec));
    assign underflow = (nxt < 0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (underflow) begin
            cnt <= '0;
        end else if (nxt > MAXV) begin
            cnt <= '1;
        end else begin
            cnt <= nxt[W-1:0];
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: counts in-flight writes per architectural register
// and raises data_hazard_ID when the instruction in ID must stall.
// Optional feature macro: SB_PERF_CNT_EN adds the stall_cycles counter.
// Ports:
//   clk, reset_n    clock and asynchronous active-low reset
//   id_valid        ID holds a valid instruction
//   id_deco         ID decode fields (rs1/rs2/rd, enables, is_mret)
//   issue_fire      ID instruction accepted into EX this cycle
//   wb_fire         WB retires this cycle; wb_rd/wb_en_rd describe its write
//   sq_fire         one tracked in-flight instruction squashed; sq_rd its rd
//   data_hazard_ID  ID must stall (registered state + current ID fields)
//   inflight        total tracked writes outstanding
//   stall_cycles    (SB_PERF_CNT_EN only) saturating count of stall cycles
//   sb_err          sticky: a decrement of a zero counter was seen
module reg_scoreboard
    import hazard_pkg::*;
#(
    parameter int  CNT_W        = 2,
    parameter int  MAX_INFLIGHT = 4,
    localparam int TOT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 id_valid,
    input  decoded_inst_t        id_deco,
    input  logic                 issue_fire,
    input  logic                 wb_fire,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 wb_en_rd,
    input  logic                 sq_fire,
    input  logic [REG_IDX_W-1:0] sq_rd,
    output logic                 data_hazard_ID,
    output logic [TOT_W-1:0]     inflight,
`ifdef SB_PERF_CNT_EN
    output logic [31:0]          stall_cycles,
`endif
    output logic                 sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [TOT_W-1:0] INFL_FULL = TOT_W'(MAX_INFLIGHT);

    // Only writes to x1..x31 are tracked; x0 traffic never touches state.
    logic issue_trk;
    logic wb_trk;
    logic sq_trk;

    assign issue_trk = issue_fire & id_deco.en_rd & (id_deco.rd != '0);
    assign wb_trk    = wb_fire & wb_en_rd & (wb_rd != '0);
    assign sq_trk    = sq_fire & (sq_rd != '0);

    logic [CNT_W-1:0] cnt [NREGS];
    logic [NREGS-1:0] reg_uf;
    logic             tot_uf;

    assign cnt[0]    = '0;
    assign reg_uf[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_reg
        logic       inc;
        logic [1:0] dec;

        assign inc = issue_trk & (id_deco.rd == REG_IDX_W'(r));
        assign dec = {1'b0, wb_trk & (wb_rd == REG_IDX_W'(r))}
                   + {1'b0, sq_trk & (sq_rd == REG_IDX_W'(r))};

        sb_counter #(.W(CNT_W)) u_cnt (
            .clk       (clk),
            .reset_n   (reset_n),
            .inc       (inc),
            .dec       (dec),
            .cnt       (cnt[r]),
            .underflow (reg_uf[r])
        );
    end

    // Total outstanding writes follow the same inc/dec events as the
    // per-register counters.
    logic [1:0] tot_dec;
    assign tot_dec = {1'b0, wb_trk} + {1'b0, sq_trk};

    sb_counter #(.W(TOT_W)) u_inflight (
        .clk       (clk),
        .reset_n   (reset_n),
        .inc       (issue_trk),
        .dec       (tot_dec),
        .cnt       (inflight),
        .underflow (tot_uf)
    );

    // Hazard terms use registered counts only: a WB this cycle does not
    // release a dependent instruction until the next cycle.
    logic rs1_busy;
    logic rs2_busy;
    logic rd_full;
    logic infl_full;
    logic mret_wait;

    assign rs1_busy  = id_deco.en_rs1 & (id_deco.rs1 != '0) & (cnt[id_deco.rs1] != '0);
    assign rs2_busy  = id_deco.en_rs2 & (id_deco.rs2 != '0) & (cnt[id_deco.rs2] != '0);
    assign rd_full   = id_deco.en_rd & (id_deco.rd != '0) & (cnt[id_deco.rd] == CNT_MAX);
    assign infl_full = id_deco.en_rd & (id_deco.rd != '0) & (inflight == INFL_FULL);
    assign mret_wait = id_deco.is_mret & (inflight != '0);

    assign data_hazard_ID = id_valid & (rs1_busy | rs2_busy | rd_full | infl_full | mret_wait);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb_err <= 1'b0;
        end else if ((|reg_uf) | tot_uf) begin
            sb_err <= 1'b1;
        end
    end

`ifdef SB_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if (data_hazard_ID && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
`timescale 1ns/1ps
module tb_reg_scoreboard;
    import hazard_pkg::*;

    localparam int CNT_W        = 2;
    localparam int MAX_INFLIGHT = 4;
    localparam int TOT_W        = 3;
    localparam int CMAX         = 3;

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b1;
    logic          id_valid = 1'b0;
    decoded_inst_t id_deco  = '0;
    logic          issue_fire = 1'b0;
    logic          wb_fire  = 1'b0;
    logic [4:0]    wb_rd    = '0;
    logic          wb_en_rd = 1'b0;
    logic          sq_fire  = 1'b0;
    logic [4:0]    sq_rd    = '0;
    logic          data_hazard_ID;
    logic [TOT_W-1:0] inflight;
    logic          sb_err;
`ifdef SB_PERF_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    reg_scoreboard #(.CNT_W(CNT_W), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .id_valid       (id_valid),
        .id_deco        (id_deco),
        .issue_fire     (issue_fire),
        .wb_fire        (wb_fire),
        .wb_rd          (wb_rd),
        .wb_en_rd       (wb_en_rd),
        .sq_fire        (sq_fire),
        .sq_rd          (sq_rd),
        .data_hazard_ID (data_hazard_ID),
        .inflight       (inflight),
`ifdef SB_PERF_CNT_EN
        .stall_cycles   (stall_cycles),
`endif
        .sb_err         (sb_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: pending writes per register, total, sticky error.
    int              m_cnt [32];
    int              m_inflight;
    bit              m_err;
    longint unsigned m_stalls;

    function automatic decoded_inst_t mk(input int rs1, input bit e1, input int rs2, input bit e2,
                                         input int rd, input bit erd, input bit mret);
        decoded_inst_t d;
        d.rs1 = 5'(rs1); d.en_rs1 = e1;
        d.rs2 = 5'(rs2); d.en_rs2 = e2;
        d.rd  = 5'(rd);  d.en_rd  = erd;
        d.is_mret = mret;
        return d;
    endfunction

    function automatic bit model_hazard();
        bit h;
        h = (id_deco.en_rs1 && id_deco.rs1 != 0 && m_cnt[id_deco.rs1] != 0)
         || (id_deco.en_rs2 && id_deco.rs2 != 0 && m_cnt[id_deco.rs2] != 0)
         || (id_deco.en_rd && id_deco.rd != 0 && m_cnt[id_deco.rd] == CMAX)
         || (id_deco.en_rd && id_deco.rd != 0 && m_inflight == MAX_INFLIGHT)
         || (id_deco.is_mret && m_inflight != 0);
        return id_valid && h;
    endfunction

    task automatic model_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_inflight = 0;
        m_err      = 1'b0;
        m_stalls   = 0;
    endtask

    task automatic set_in(input bit v, input decoded_inst_t d, input bit iss,
                          input bit wf, input bit wen, input int wr, input bit sf, input int sr);
        id_valid   = v;
        id_deco    = d;
        issue_fire = iss;
        wb_fire    = wf;
        wb_en_rd   = wen;
        wb_rd      = 5'(wr);
        sq_fire    = sf;
        sq_rd      = 5'(sr);
    endtask

    // Advance one clock and apply the scoreboard rules to the model.
    task automatic step();
        bit hz;
        int n;
        int d;
        hz = model_hazard();
        vectors++;
        if (issue_fire && data_hazard_ID) begin
            miscompares++;
            $display("FAIL issue_under_hazard t=%0t got hazard=%b with issue=1, required hazard=0", $time, data_hazard_ID);
        end
        @(posedge clk);
        if (reset_n) begin
            for (int r = 1; r < 32; r++) begin
                n = m_cnt[r];
                if (issue_fire && id_deco.en_rd && int'(id_deco.rd) == r) n++;
                if (wb_fire && wb_en_rd && int'(wb_rd) == r) n--;
                if (sq_fire && int'(sq_rd) == r) n--;
                if (n < 0) begin n = 0; m_err = 1'b1; end
                if (n > CMAX) n = CMAX;
                m_cnt[r] = n;
            end
            d = 0;
            if (issue_fire && id_deco.en_rd && id_deco.rd != 0) d++;
            if (wb_fire && wb_en_rd && wb_rd != 0) d--;
            if (sq_fire && sq_rd != 0) d--;
            m_inflight = m_inflight + d;
            if (m_inflight < 0) begin m_inflight = 0; m_err = 1'b1; end
            if (m_inflight > 7) m_inflight = 7;
            if (hz && m_stalls != 64'hFFFF_FFFF) m_stalls++;
        end
        #1;
    endtask

    task automatic test_reset();
        #2;
        reset_n = 1'b0;
        set_in(0, '0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (inflight !== 3'd0) begin miscompares++; $display("FAIL reset_inflight got %0d want 0", inflight); end
        vectors++; if (sb_err !== 1'b0) begin miscompares++; $display("FAIL reset_sb_err got %b want 0", sb_err); end
        vectors++; if (data_hazard_ID !== 1'b0) begin miscompares++; $display("FAIL reset_hazard got %b want 0", data_hazard_ID); end
        reset_n = 1'b1;
    endtask

    task automatic test_raw();
        set_in(1, mk(0, 0, 0, 0, 5, 1, 0), 1, 0, 0, 0, 0, 0);
        #1;
        vectors++; if (data_hazard_ID !== 1'b0) begin miscompares++; $display("FAIL raw_issue got %b want 0", data_hazard_ID); end
        step();
        set_in(1, mk(5, 1, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (data_hazard_ID !== 1'b1) begin miscompares++; $display("FAIL raw_pending[%0d] got %b want 1", i, data_hazard_ID); end
            step();
        end
        vectors++; if (inflight !== 3'd1) begin miscompares++; $display("FAIL raw_inflight got %0d want 1", inflight); end
        set_in(1, mk(5, 1, 0, 0, 0, 0, 0), 0, 1, 1, 5, 0, 0);
        #1;
        vectors++; if (data_hazard_ID !== 1'b1) begin miscompares++; $display("FAIL raw_no_bypass got %b want 1", data_hazard_ID); end
        step();
        set_in(1, mk(5, 1, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0);
        #1;
        vectors++; if (data_hazard_ID !== 1'b0) begin miscompares++; $display("FAIL raw_cleared got %b want 0", data_hazard_ID); end
        vectors++; if (inflight !== 3'd0) begin miscompares++; $display("FAIL raw_drained got %0d want 0", inflight); end
    endtask

    task automatic test_saturate();
        set_in(1, mk(0, 0, 0, 0, 7, 1, 0), 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (data_hazard_ID !== 1'b0) begin miscompares++; $display("FAIL sat_issue[%0d] got %b want 0", i, data_hazard_ID); end
            step();
        end
        set_in(1, mk(0, 0, 0, 0, 7, 1, 0), 0, 0, 0, 0, 0, 0);
        #1;
        vectors++; if (data_hazard_ID !== 1'b1) begin miscompares++; $display("FAIL sat_full got %b want 1", data_hazard_ID); end
        vectors++; if (inflight !== 3'd3) begin miscompares++; $display("FAIL sat_inflight got %0d want 3", inflight); end
        set_in(1, mk(0, 0, 0, 0, 7, 1, 0), 0, 1, 1, 7, 0, 0);
        #1;
        vectors++; if (data_hazard_ID !== 1'b1) begin miscompares++; $display("FAIL sat_wb_same_cycle got %b want 1", data_hazard_ID); end
        step();
        set_in(1, mk(0, 0, 0, 0, 7, 1, 0), 0, 0, 0, 0, 0, 0);
        #1;
        vectors++; if (data_hazard_ID !== 1'b0) begin miscompares++; $display("FAIL sat_after_wb got %b want 0", data_hazard_ID); end
        vectors++; if (inflight !== 3'd2) begin miscompares++; $display("FAIL sat_inflight2 got %0d want 2", inflight); end
        // WB and squash on the same register retire two writes at once.
        set_in(0, '0, 0, 1, 1, 7, 1, 7);
        step();
        set_in(0, '0, 0, 0, 0, 0, 0, 0);
        #1;
        vectors++; if (inflight !== 3'd0) begin miscompares++; $display("FAIL sat_dual_dec got %0d want 0", inflight); end
        vectors++; if (sb_err !== 1'b0) begin miscompares++; $display("FAIL sat_dual_err got %b want 0", sb_err); end
    endtask

    task automatic test_inflight_full();
        for (int r = 1; r <= 4; r++) begin
            set_in(1, mk(0, 0, 0, 0, r, 1, 0), 1, 0, 0, 0, 0, 0);
            #1;
            vectors++; if (data_hazard_ID !== 1'b0) begin miscompares++; $display("FAIL full_issue[x%0d] got %b want 0", r, data_hazard_ID); end
            step();
        end
        set_in(1, mk(0, 0, 0, 0, 10, 1, 0), 0, 0, 0, 0, 0, 0);
        #1;
        vectors++; if (data_hazard_ID !== 1'b1) begin miscompares++; $display("FAIL full_write got %b want 1", data_hazard_ID); end
        vectors++; if (inflight !== 3'd4) begin miscompares++; $display("FAIL full_inflight got %0d want 4", inflight); end
        set_in(1, mk(11, 1, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0);
        #1;
        vectors++; if (data_hazard_ID !== 1'b0) begin miscompares++; $display("FAIL full_readonly got %b want 0", data_hazard_ID); end
        set_in(0, '0, 0, 1, 1, 1, 1, 2);
        step();
        set_in(0, '0, 0, 1, 1, 3, 1, 4);
        step();
        set_in(0, '0, 0, 0, 0, 0, 0, 0);
        #1;
        vectors++; if (inflight !== 3'd0) begin miscompares++; $display("FAIL full_drained got %0d want 0", inflight); end
    endtask

    task automatic test_net();
        set_in(1, mk(0, 0, 0, 0, 3, 1, 0), 1, 0, 0, 0, 0, 0);
        step();
        set_in(1, mk(0, 0, 0, 0, 3, 1, 0), 1, 1, 1, 3, 0, 0);
        #1;
        vectors++; if (data_hazard_ID !== 1'b0) begin miscompares++; $display("FAIL net_issue got %b want 0", data_hazard_ID); end
        step();
        set_in(1, mk(3, 1, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0);
        #1;
        vectors++; if (data_hazard_ID !== 1'b1) begin miscompares++; $display("FAIL net_cnt_kept got %b want 1", data_hazard_ID); end
        vectors++; if (inflight !== 3'd1) begin miscompares++; $display("FAIL net_inflight got %0d want 1", inflight); end
        set_in(0, '0, 0, 1, 1, 3, 0, 0);
        step();
        set_in(0, '0, 0, 0, 0, 0, 0, 0);
        #1;
        vectors++; if (inflight !== 3'd0) begin miscompares++; $display("FAIL net_drained got %0d want 0", inflight); end
    endtask

    task automatic test_mret();
        set_in(1, mk(0, 0, 0, 0, 1, 1, 0), 1, 0, 0, 0, 0, 0);
        step();
        set_in(1, mk(0, 0, 0, 0, 2, 1, 0), 1, 0, 0, 0, 0, 0);
        step();
        set_in(1, mk(0, 0, 0, 0, 0, 0, 1), 0, 0, 0, 0, 0, 0);
        #1;
        vectors++; if (data_hazard_ID !== 1'b1) begin miscompares++; $display("FAIL mret_wait2 got %b want 1", data_hazard_ID); end
        vectors++; if (inflight !== 3'd2) begin miscompares++; $display("FAIL mret_inflight got %0d want 2", inflight); end
        set_in(1, mk(0, 0, 0, 0, 0, 0, 1), 0, 1, 1, 1, 0, 0);
        step();
        set_in(1, mk(0, 0, 0, 0, 0, 0, 1), 0, 0, 0, 0, 0, 0);
        #1;
        vectors++; if (data_hazard_ID !== 1'b1) begin miscompares++; $display("FAIL mret_wait1 got %b want 1", data_hazard_ID); end
        set_in(1, mk(0, 0, 0, 0, 0, 0, 1), 0, 1, 1, 2, 0, 0);
        step();
        set_in(1, mk(0, 0, 0, 0, 0, 0, 1), 0, 0, 0, 0, 0, 0);
        #1;
        vectors++; if (data_hazard_ID !== 1'b0) begin miscompares++; $display("FAIL mret_drained got %b want 0", data_hazard_ID); end
    endtask

    task automatic test_underflow_reset();
        set_in(0, '0, 0, 1, 1, 9, 0, 0);
        step();
        set_in(0, '0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (sb_err !== 1'b1) begin miscompares++; $display("FAIL err_sticky[%0d] got %b want 1", i, sb_err); end
            step();
        end
        vectors++; if (inflight !== 3'd0) begin miscompares++; $display("FAIL err_inflight_held got %0d want 0", inflight); end
        set_in(1, mk(0, 0, 0, 0, 9, 1, 0), 1, 0, 0, 0, 0, 0);
        #1;
        vectors++; if (data_hazard_ID !== 1'b0) begin miscompares++; $display("FAIL err_cnt9_zero got %b want 0", data_hazard_ID); end
        step();
        set_in(1, mk(0, 0, 0, 0, 4, 1, 0), 1, 0, 0, 0, 0, 0);
        step();
        set_in(0, '0, 0, 0, 0, 0, 0, 0);
        #1;
        vectors++; if (inflight !== 3'd2) begin miscompares++; $display("FAIL rst_pre_inflight got %0d want 2", inflight); end
        reset_n = 1'b0;
        model_reset();
        #1;
        vectors++; if (inflight !== 3'd0) begin miscompares++; $display("FAIL rst_mid_inflight got %0d want 0", inflight); end
        vectors++; if (sb_err !== 1'b0) begin miscompares++; $display("FAIL rst_mid_sb_err got %b want 0", sb_err); end
        step();
        reset_n = 1'b1;
        set_in(1, mk(9, 1, 4, 1, 0, 0, 1), 0, 0, 0, 0, 0, 0);
        #1;
        vectors++; if (data_hazard_ID !== 1'b0) begin miscompares++; $display("FAIL rst_state_clear got %b want 0", data_hazard_ID); end
    endtask

    task automatic test_x0();
`ifdef SB_PERF_CNT_EN
        logic [31:0] base;
`endif
        set_in(1, mk(0, 1, 0, 1, 0, 1, 0), 1, 0, 0, 0, 0, 0);
        #1;
        vectors++; if (data_hazard_ID !== 1'b0) begin miscompares++; $display("FAIL x0_issue got %b want 0", data_hazard_ID); end
        step();
        #1;
        vectors++; if (inflight !== 3'd0) begin miscompares++; $display("FAIL x0_inflight got %0d want 0", inflight); end
        vectors++; if (data_hazard_ID !== 1'b0) begin miscompares++; $display("FAIL x0_read got %b want 0", data_hazard_ID); end
`ifdef SB_PERF_CNT_EN
        base = stall_cycles;
        set_in(1, mk(0, 0, 0, 0, 8, 1, 0), 1, 0, 0, 0, 0, 0);
        step();
        set_in(1, mk(8, 1, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0);
        repeat (4) step();
        set_in(1, mk(8, 1, 0, 0, 0, 0, 0), 0, 1, 1, 8, 0, 0);
        step();
        set_in(0, '0, 0, 0, 0, 0, 0, 0);
        #1;
        vectors++; if (stall_cycles - base !== 32'd5) begin miscompares++; $display("FAIL perf_five_stalls got %0d want 5", stall_cycles - base); end
`endif
    endtask

    task automatic test_random();
        decoded_inst_t d;
        int  pend[$];
        bit  v, iss, wf, wen, sf;
        int  wr, sr;
        for (int c = 0; c < 400; c++) begin
            d = mk($urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                   1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 15) == 0));
            v = ($urandom_range(0, 3) != 0);
            id_valid = v;
            id_deco  = d;
            iss = v && !model_hazard() && ($urandom_range(0, 1) == 1);
            pend.delete();
            for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) pend.push_back(r);
            wf = 0; wen = 0; sf = 0; wr = 0; sr = 0;
            if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
                wf = 1; wen = 1; wr = pend[$urandom_range(0, pend.size() - 1)];
            end else if ($urandom_range(0, 7) == 0) begin
                wf = 1; wen = 0; wr = $urandom_range(0, 31);
            end
            if (pend.size() > 0 && $urandom_range(0, 4) == 0) begin
                sr = pend[$urandom_range(0, pend.size() - 1)];
                sf = !(wf && wen && sr == wr && m_cnt[sr] < 2);
                if (!sf) sr = 0;
            end
            set_in(v, d, iss, wf, wen, wr, sf, sr);
            #1;
            vectors++; if (data_hazard_ID !== model_hazard()) begin miscompares++; $display("FAIL rnd_hazard c=%0d got %b want %b", c, data_hazard_ID, model_hazard()); end
            vectors++; if (int'(inflight) !== m_inflight) begin miscompares++; $display("FAIL rnd_inflight c=%0d got %0d want %0d", c, inflight, m_inflight); end
            vectors++; if (sb_err !== m_err) begin miscompares++; $display("FAIL rnd_sb_err c=%0d got %b want %b", c, sb_err, m_err); end
`ifdef SB_PERF_CNT_EN
            vectors++; if (stall_cycles !== 32'(m_stalls)) begin miscompares++; $display("FAIL rnd_stalls c=%0d got %0d want %0d", c, stall_cycles, m_stalls); end
`endif
            step();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_raw();
        test_saturate();
        test_inflight_full();
        test_net();
        test_mret();
        test_underflow_reset();
        test_x0();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t, required completion before 200000", $time);
        $fatal(1, "timeout");
    end

endmodule
